cpu_mem_responder: RTL

Memory-side responder for the CPU's data/instruction bus. It accepts word requests (address, read/write select, write data), holds them through a configurable wait-state interval, then completes them against an internal word-addressed RAM with a one-cycle ready pulse. It sits between the CPU core and local memory, and provides an explicit completion handshake plus out-of-range error reporting that the core bus otherwise lacks.

---
 rtl/cpu_mem_responder_if.sv | 21 ++
 rtl/cpu_mem_responder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder_if.sv
// CPU <-> memory responder bus: request fields from the core, completion back.
interface cpu_mem_responder_if;
  logic        req;
  logic [31:0] address;
  logic        rw;
  logic [31:0] datai;
  logic [31:0] datao;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, address, rw, datai,
    input  datao, ready, err, busy
  );

  modport slave (
    input  req, address, rw, datai,
    output datao, ready, err, busy
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: latches a CPU word request, waits WAIT_CYCLES, then
// completes it against a local RAM with a one-cycle ready pulse and range error.
module cpu_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE        = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  cpu_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] datao_q, datao_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic        enter_resp;
  logic        mem_we;
  logic [31:0] idx;
  logic        in_range;

  logic [31:0] mem_q [2**ADDR_W];

  // Next-state, request latching and the RAM access done on entry to StResp.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    datao_d    = datao_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    enter_resp = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          addr_d  = bus.address;
          rw_d    = bus.rw;
          wdata_d = bus.datai;
          if (WAIT_CYCLES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Use the _d copies so a zero-wait request is served from the accepting edge.
    idx      = addr_d - BASE;
    in_range = (addr_d >= BASE) && ((idx >> ADDR_W) == 32'd0);

    if (enter_resp) begin
      ready_d = 1'b1;
      err_d   = ~in_range;
      if (rw_d) begin
        datao_d = in_range ? mem_q[idx[ADDR_W-1:0]] : 32'd0;
      end else begin
        mem_we = in_range;
      end
    end
  end

  // Control and response registers; RAM contents survive reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      rw_q    <= 1'b0;
      wdata_q <= 32'd0;
      datao_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      datao_q <= datao_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Word RAM write port, committed on the edge that enters StResp.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx[ADDR_W-1:0]] <= wdata_d;
    end
  end

  assign bus.datao = datao_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != StIdle);

endmodule
